cbus_arbiter2: RTL and testbench
================================

# cbus_arbiter2

Two-master to one-slave arbiter for the core's cbus. It sits directly upstream of the MMU and merges the instruction-fetch request and the data request into the single `cbus_req_t` stream the MMU translates. It holds the selected request stable for the whole transaction, including every page-walk step the MMU performs on it. It routes the MMU's response back to the master that owns the transaction.

## Interface
Parameters:
- `ROUND_ROBIN`, default 1: 1 = round-robin between ports; 0 = fixed priority, port 1 (data) always wins.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ireq` in `cbus_req_t`: port 0 request (instruction fetch).
- `iresp` out `cbus_resp_t`: port 0 response.
- `dreq` in `cbus_req_t`: port 1 request (data).
- `dresp` out `cbus_resp_t`: port 1 response.
- `oreq` out `cbus_req_t`: request to the MMU's core-side input.
- `oresp` in `cbus_resp_t`: response from the MMU.
- `grant` out 1: index of the port owning the current or most recent transaction.
- `busy` out 1: high while in BUSY.

## Operation
- State machine with two states: IDLE and BUSY.
- IDLE, no request valid: stay in IDLE; `oreq.valid`=0.
- IDLE, at least one `*.valid` high: pick a winner, latch the winner's full request (all fields) into the `oreq` register, set `oreq.valid`=1, set `grant`=winner, go to BUSY.
- Winner selection:
  - Only one port valid: that port wins.
  - Both valid, `ROUND_ROBIN`=1: the port not equal to `last_grant` wins.
  - Both valid, `ROUND_ROBIN`=0: port 1 wins.
- `last_grant` updates to the winner at each grant.
- BUSY: `oreq` is frozen. Later changes on either input are ignored. The MMU reads `addr` from `oreq` during its walk, so it must not change.
- BUSY, `oresp.ready && oresp.last`:
  - Go to IDLE.
  - Clear `oreq.valid` and `oreq.strobe`; other `oreq` fields may hold.
- Response routing is combinational:
  - The granted port's resp = `oresp` while `busy`.
  - The other port's resp = all zero.
  - In IDLE, both resps are all zero.
- `oresp.ready` without `last` (burst beats) is forwarded to the owner and does not end the transaction.
- Masters keep `valid` high and their request stable until they see `ready && last`. The arbiter does not depend on this after the grant.

## Timing
- Reset (async assert) sets:
  - State IDLE.
  - `oreq` all fields 0.
  - `grant`=0, `busy`=0.
  - `iresp`/`dresp` all 0.
  - `last_grant`=1, so the first tie goes to port 0.
- Grant latency: a request valid in IDLE during cycle t gives `oreq.valid`=1 and `busy`=1 from cycle t+1.
- Response: `oresp.ready && last` in cycle n:
  - Appears on the owner's resp in cycle n (zero added latency).
  - `oreq.valid`=0 and `busy`=0 from cycle n+1.
- Back-to-back: a pending request on either port in cycle n+1 is granted at the n+1 edge, so `oreq.valid` is high again at n+2. This gives at least one valid-low cycle between transactions, which covers the MMU's one-cycle return to its idle state.
- Simultaneous new request and end of transaction in the same cycle: no grant in that cycle; the request is considered in IDLE the next cycle.
- Reset asserted mid-transaction: immediately return to the reset values, and no response is forwarded. The MMU is reset on the same reset.
- Fairness: with both ports continuously valid and `ROUND_ROBIN`=1, grants strictly alternate 0,1,0,1.

## Test plan
- Single fetch: `ireq` valid, addr=0x8000_0000, MMU model replies ready+last, data=0x13, after 4 cycles -> `oreq.valid` at t+1 with addr 0x8000_0000; `iresp.data`=0x13 in the reply cycle; `dresp` stays 0; `busy` low the next cycle.
- Tie after reset: both valid in cycle 0 -> `grant`=0 first. After completion, port 1 is granted with `oreq.valid` high 2 cycles after the port-0 response. Then alternates 0,1,0,1 over 8 transactions.
- Fixed priority (`ROUND_ROBIN`=0), both continuously valid -> 4 consecutive grants to port 1; port 0 is granted only once `dreq.valid` drops.
- Stability: in BUSY, change `dreq.addr` and `ireq.addr` every cycle over a 12-cycle walk -> `oreq` stays bit-identical to the latched request until ready+last.
- Non-last beat: `oresp.ready`=1, `last`=0, then `ready`+`last` 2 cycles later -> both beats are forwarded to the owner and the arbiter stays BUSY until the last beat.
- Reset mid-walk: drop `rst_n` asynchronously 3 cycles into BUSY -> `oreq.valid`, `busy`, `grant` and both resps are 0 immediately. After release with `ireq` valid, the grant occurs normally.

Source files
------------

// File: rtl/cbus_arbiter2.sv
// cbus_arbiter2: merges the fetch and data cbus requests into one MMU stream.
// The granted request is latched and frozen until the MMU signals ready+last.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  len;
        logic        burst;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

module cbus_arbiter2
    import cbus_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       grant,
    output logic       busy
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t    state_q;
    cbus_req_t oreq_q;
    logic      grant_q;
    logic      last_grant_q;

    logic      any_valid;
    logic      both_valid;
    logic      d_only;
    logic      done;
    logic      win;

    assign any_valid  = ireq.valid | dreq.valid;
    assign both_valid = ireq.valid & dreq.valid;
    assign d_only     = dreq.valid & ~ireq.valid;
    assign done       = oresp.ready & oresp.last;

    // Ties go to the port that did not win last time, or to data when fixed.
    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            both_valid: win = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b1;
            d_only:     win = 1'b1;
            default:    win = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            oreq_q       <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (any_valid) begin
                        oreq_q       <= win ? dreq : ireq;
                        grant_q      <= win;
                        last_grant_q <= win;
                        state_q      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (done) begin
                        oreq_q.valid  <= 1'b0;
                        oreq_q.strobe <= '0;
                        state_q       <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Only the owner sees the MMU response, and only while a transaction is open.
    always_comb begin
        iresp = '0;
        dresp = '0;
        if (state_q == S_BUSY) begin
            if (grant_q) begin
                dresp = oresp;
            end else begin
                iresp = oresp;
            end
        end
    end

    assign oreq  = oreq_q;
    assign grant = grant_q;
    assign busy  = (state_q == S_BUSY);

endmodule

// File: tb/tb_cbus_arbiter2.sv
// tb_cbus_arbiter2: table, directed and randomized checks of cbus_arbiter2.
// The random phase compares against an owner/last-winner model of the rules.
`timescale 1ns/1ps
module tb_cbus_arbiter2;
    import cbus_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    initial forever #5 clk = ~clk;

    cbus_req_t  ireq, dreq, oreq;
    cbus_resp_t iresp, dresp, oresp;
    logic       grant, busy;

    cbus_req_t  f_ireq, f_dreq, f_oreq;
    cbus_resp_t f_iresp, f_dresp, f_oresp;
    logic       f_grant, f_busy;

    cbus_arbiter2 #(.ROUND_ROBIN(1)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp),
        .grant (grant),
        .busy  (busy)
    );

    cbus_arbiter2 #(.ROUND_ROBIN(0)) u_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .ireq  (f_ireq),
        .iresp (f_iresp),
        .dreq  (f_dreq),
        .dresp (f_dresp),
        .oreq  (f_oreq),
        .oresp (f_oresp),
        .grant (f_grant),
        .busy  (f_busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic iv;
        logic dv;
        logic rdy;
        logic lst;
        logic e_busy;
        logic e_grant;
        logic e_fi;
        logic e_fd;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic cbus_req_t mk_req(input logic v, input logic [31:0] a);
        cbus_req_t r;
        r.valid    = v;
        r.is_write = 1'($urandom_range(0, 1));
        r.addr     = a;
        r.size     = 2'($urandom_range(0, 3));
        r.len      = 4'($urandom_range(0, 15));
        r.burst    = 1'($urandom_range(0, 1));
        r.strobe   = 4'($urandom_range(0, 15));
        r.data     = $urandom;
        return r;
    endfunction

    function automatic cbus_resp_t mk_rsp(input logic r, input logic l,
                                          input logic [31:0] d);
        cbus_resp_t s;
        s.ready = r;
        s.last  = l;
        s.data  = d;
        return s;
    endfunction

    task automatic do_reset();
        rst_n   = 1'b0;
        ireq    = '0;
        dreq    = '0;
        oresp   = '0;
        f_ireq  = '0;
        f_dreq  = '0;
        f_oresp = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    // Reference model state for the random phase
    int         m_owner;
    logic       m_grant;
    logic       m_last;
    cbus_req_t  m_held;
    cbus_resp_t e_i, e_d;
    cbus_req_t  s_req;

    initial begin
        tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 1, 1, 0, 1};
        tbl[4]  = '{1, 1, 1, 0, 1, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 1, 1, 1, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 1, 1, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 1, 1, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 1, 1, 0, 1};
        tbl[11] = '{0, 1, 0, 0, 0, 1, 0, 0};
        tbl[12] = '{1, 1, 1, 1, 1, 1, 0, 1};
        tbl[13] = '{1, 1, 0, 0, 0, 1, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 0, 1, 0};
        tbl[15] = '{0, 0, 1, 1, 1, 0, 1, 0};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 0, 0};

        // Reset values, with live inputs that must be ignored
        rst_n   = 1'b0;
        ireq    = mk_req(1'b1, 32'h1234_0000);
        dreq    = mk_req(1'b1, 32'h5678_0000);
        oresp   = mk_rsp(1'b1, 1'b1, 32'hdead_beef);
        f_ireq  = '0;
        f_dreq  = '0;
        f_oresp = '0;
        #13;
        chk("rst_oreq", 96'(oreq), 96'(0));
        chk("rst_grant", 96'(grant), 96'(0));
        chk("rst_busy", 96'(busy), 96'(0));
        chk("rst_iresp", 96'(iresp), 96'(0));
        chk("rst_dresp", 96'(dresp), 96'(0));
        do_reset();

        // Table: tie after reset, back-to-back, burst beats, overlap
        for (int i = 0; i < 17; i++) begin
            ireq  = mk_req(tbl[i].iv, 32'h0000_1000 + 32'(i));
            dreq  = mk_req(tbl[i].dv, 32'h0000_2000 + 32'(i));
            oresp = mk_rsp(tbl[i].rdy, tbl[i].lst, 32'h0000_a000 + 32'(i));
            #3;
            e_i = '0;
            e_d = '0;
            if (tbl[i].e_fi) e_i = oresp;
            if (tbl[i].e_fd) e_d = oresp;
            chk($sformatf("tbl%0d_busy", i), 96'(busy), 96'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_valid", i), 96'(oreq.valid), 96'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_grant", i), 96'(grant), 96'(tbl[i].e_grant));
            chk($sformatf("tbl%0d_iresp", i), 96'(iresp), 96'(e_i));
            chk($sformatf("tbl%0d_dresp", i), 96'(dresp), 96'(e_d));
            cyc();
        end

        // Single fetch
        do_reset();
        ireq = mk_req(1'b1, 32'h8000_0000);
        #3;
        chk("sf_idle_valid", 96'(oreq.valid), 96'(0));
        cyc();
        #3;
        chk("sf_valid", 96'(oreq.valid), 96'(1));
        chk("sf_addr", 96'(oreq.addr), 96'(32'h8000_0000));
        chk("sf_grant", 96'(grant), 96'(0));
        repeat (3) cyc();
        oresp = mk_rsp(1'b1, 1'b1, 32'h13);
        #3;
        chk("sf_idata", 96'(iresp.data), 96'(32'h13));
        chk("sf_iready", 96'(iresp.ready), 96'(1));
        chk("sf_dresp", 96'(dresp), 96'(0));
        cyc();
        ireq  = '0;
        oresp = '0;
        #3;
        chk("sf_busy_after", 96'(busy), 96'(0));
        chk("sf_valid_after", 96'(oreq.valid), 96'(0));
        cyc();

        // Stability over a 12-cycle walk
        s_req        = mk_req(1'b1, 32'hc000_1000);
        s_req.strobe = 4'hf;
        ireq         = s_req;
        cyc();
        for (int k = 0; k < 12; k++) begin
            ireq.addr  = $urandom;
            dreq       = mk_req(1'b1, $urandom);
            #3;
            chk($sformatf("stab%0d", k), 96'(oreq), 96'(s_req));
            cyc();
        end
        oresp = mk_rsp(1'b1, 1'b1, 32'h77);
        #3;
        chk("stab_end_iresp", 96'(iresp), 96'(mk_rsp(1'b1, 1'b1, 32'h77)));
        cyc();
        ireq  = '0;
        dreq  = '0;
        oresp = '0;
        #3;
        chk("stab_clr_valid", 96'(oreq.valid), 96'(0));
        chk("stab_clr_strobe", 96'(oreq.strobe), 96'(0));
        cyc();

        // Reset mid-walk while a data transaction is open
        dreq = mk_req(1'b1, 32'h4000_0040);
        cyc();
        repeat (3) cyc();
        oresp = mk_rsp(1'b1, 1'b0, 32'h55);
        #2;
        chk("rmw_pre_dresp", 96'(dresp.ready), 96'(1));
        chk("rmw_pre_grant", 96'(grant), 96'(1));
        rst_n = 1'b0;
        #1;
        chk("rmw_valid", 96'(oreq.valid), 96'(0));
        chk("rmw_busy", 96'(busy), 96'(0));
        chk("rmw_grant", 96'(grant), 96'(0));
        chk("rmw_iresp", 96'(iresp), 96'(0));
        chk("rmw_dresp", 96'(dresp), 96'(0));
        dreq  = '0;
        ireq  = mk_req(1'b1, 32'h8000_0100);
        oresp = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #3;
        chk("rmw_regrant_busy", 96'(busy), 96'(1));
        chk("rmw_regrant_grant", 96'(grant), 96'(0));
        chk("rmw_regrant_addr", 96'(oreq.addr), 96'(32'h8000_0100));
        oresp = mk_rsp(1'b1, 1'b1, 32'h0);
        cyc();
        ireq  = '0;
        oresp = '0;
        cyc();

        // Round-robin fairness over 8 transactions
        do_reset();
        ireq = mk_req(1'b1, 32'h0000_0100);
        dreq = mk_req(1'b1, 32'h0000_0200);
        for (int k = 0; k < 8; k++) begin
            #3;
            chk($sformatf("rr%0d_idle", k), 96'(busy), 96'(0));
            cyc();
            oresp = mk_rsp(1'b1, 1'b1, 32'(k));
            #3;
            chk($sformatf("rr%0d_grant", k), 96'(grant), 96'(k % 2));
            chk($sformatf("rr%0d_route", k), 96'(k % 2 == 0 ? iresp.ready : dresp.ready),
                96'(1));
            cyc();
            oresp = '0;
        end
        ireq = '0;
        dreq = '0;
        cyc();

        // Fixed priority: data always wins while valid
        f_ireq = mk_req(1'b1, 32'h0000_0300);
        f_dreq = mk_req(1'b1, 32'h0000_0400);
        for (int k = 0; k < 4; k++) begin
            #3;
            chk($sformatf("fp%0d_idle", k), 96'(f_busy), 96'(0));
            cyc();
            f_oresp = mk_rsp(1'b1, 1'b1, 32'h0);
            #3;
            chk($sformatf("fp%0d_grant", k), 96'(f_grant), 96'(1));
            chk($sformatf("fp%0d_addr", k), 96'(f_oreq.addr), 96'(32'h0000_0400));
            cyc();
            f_oresp = '0;
        end
        f_dreq = '0;
        cyc();
        #3;
        chk("fp_port0_busy", 96'(f_busy), 96'(1));
        chk("fp_port0_grant", 96'(f_grant), 96'(0));
        f_oresp = mk_rsp(1'b1, 1'b1, 32'h0);
        cyc();
        f_ireq  = '0;
        f_oresp = '0;
        cyc();

        // Randomized traffic against the reference model
        do_reset();
        m_owner = -1;
        m_grant = 1'b0;
        m_last  = 1'b1;
        m_held  = '0;
        for (int n = 0; n < 400; n++) begin
            ireq  = mk_req(1'($urandom_range(0, 2) != 0), $urandom);
            dreq  = mk_req(1'($urandom_range(0, 2) != 0), $urandom);
            oresp = mk_rsp(1'($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 1)), $urandom);
            #3;
            e_i = '0;
            e_d = '0;
            if (m_owner == 0) e_i = oresp;
            if (m_owner == 1) e_d = oresp;
            chk("rnd_busy", 96'(busy), 96'(m_owner >= 0));
            chk("rnd_grant", 96'(grant), 96'(m_grant));
            chk("rnd_iresp", 96'(iresp), 96'(e_i));
            chk("rnd_dresp", 96'(dresp), 96'(e_d));
            if (m_owner >= 0) begin
                chk("rnd_oreq", 96'(oreq), 96'(m_held));
            end else begin
                chk("rnd_idle_valid", 96'({oreq.valid, oreq.strobe}), 96'(0));
            end
            if (m_owner >= 0) begin
                if (oresp.ready && oresp.last) m_owner = -1;
            end else if (ireq.valid || dreq.valid) begin
                if (ireq.valid && dreq.valid) m_owner = m_last ? 0 : 1;
                else m_owner = dreq.valid ? 1 : 0;
                m_grant = 1'(m_owner);
                m_last  = 1'(m_owner);
                m_held  = (m_owner == 1) ? dreq : ireq;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
